nn_sequencer: RTL

- Control FSM that sequences one neural_network datapath instance: weight load, layer-by-layer inference, result readout.
- Drives the datapath's layer/node addresses, write_enable, input_select and accumulator reset.
- Exposes valid/ready streams to the host for weights, input vector and output vector.
- Sits between the host interface and the datapath; one sequencer per datapath.

---
 rtl/nn_sequencer_if.sv | 52 +++++
 rtl/nn_sequencer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/nn_sequencer_if.sv
// Signal bundle between nn_sequencer and its environment.
// The environment is the host stream side plus the neural_network datapath.
// master = environment (host + datapath model), slave = the sequencer.
interface nn_sequencer_if #(
    parameter int LAYER_SIZE  = 3,
    parameter int LAYER_DEPTH = 4,
    parameter int BIT_SIZE    = 8
);
    // A single layer or node still needs a one-bit address.
    localparam int LW = (LAYER_DEPTH > 1) ? $clog2(LAYER_DEPTH) : 1;
    localparam int NW = (LAYER_SIZE  > 1) ? $clog2(LAYER_SIZE)  : 1;

    // Host commands and status
    logic                cmd_load;
    logic                cmd_run;
    logic                busy;
    logic                done;

    // Host input stream (weights or input vector)
    logic                in_valid;
    logic                in_ready;
    logic [BIT_SIZE-1:0] in_data;

    // Host output stream (result vector)
    logic                out_valid;
    logic                out_ready;
    logic [BIT_SIZE-1:0] out_data;
    logic                out_last;

    // Datapath control and data
    logic                nn_write_enable;
    logic                nn_input_select;
    logic [LW-1:0]       nn_layer;
    logic [NW-1:0]       nn_node;
    logic                nn_clr;
    logic [BIT_SIZE-1:0] nn_data_in;
    logic [BIT_SIZE-1:0] nn_y;

    modport master (
        output cmd_load, cmd_run, in_valid, in_data, out_ready, nn_y,
        input  busy, done, in_ready, out_valid, out_data, out_last,
        input  nn_write_enable, nn_input_select, nn_layer, nn_node,
        input  nn_clr, nn_data_in
    );

    modport slave (
        input  cmd_load, cmd_run, in_valid, in_data, out_ready, nn_y,
        output busy, done, in_ready, out_valid, out_data, out_last,
        output nn_write_enable, nn_input_select, nn_layer, nn_node,
        output nn_clr, nn_data_in
    );
endinterface

// File: rtl/nn_sequencer.sv
// Control FSM for one neural_network datapath instance.
// It loads the weight image, runs inference layer by layer, then streams
// the result vector back to the host.
//
// Flow: IDLE -> LOAD -> IDLE                                   (weight load)
//       IDLE -> CLR -> RUN_IN -> SETTLE -> CLR -> RUN_FB -> SETTLE ... ->
//               OUT_FETCH <-> OUT_PRESENT -> IDLE               (inference)
module nn_sequencer #(
    parameter int LAYER_SIZE  = 3,
    parameter int LAYER_DEPTH = 4,
    parameter int BIT_SIZE    = 8,
    parameter int PIPE_LAT    = 2     // must be >= 1
) (
    input  logic          clk,
    input  logic          rst,        // asynchronous, active low
    nn_sequencer_if.slave bus
);

    localparam int LW = (LAYER_DEPTH > 1) ? $clog2(LAYER_DEPTH) : 1;
    localparam int NW = (LAYER_SIZE  > 1) ? $clog2(LAYER_SIZE)  : 1;
    localparam int SW = (PIPE_LAT    > 1) ? $clog2(PIPE_LAT)    : 1;

    localparam logic [LW-1:0] LAYER_LAST  = LW'(LAYER_DEPTH - 1);
    localparam logic [NW-1:0] NODE_LAST   = NW'(LAYER_SIZE - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(PIPE_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CLR,
        S_RUN_IN,
        S_RUN_FB,
        S_SETTLE,
        S_OUT_FETCH,
        S_OUT_PRESENT
    } state_t;

    state_t              r_state;
    logic [LW-1:0]       r_layer;
    logic [NW-1:0]       r_node;      // node address; also the readout index
    logic [SW-1:0]       r_settle;

    // Registered outputs, updated together with the state they belong to.
    logic                r_busy;
    logic                r_done;
    logic                r_in_ready;
    logic                r_input_select;
    logic                r_clr;
    logic                r_out_valid;
    logic                r_out_last;
    logic [BIT_SIZE-1:0] r_out_data;

    logic                w_in_fire;
    logic                w_out_fire;
    logic                w_node_last;
    logic                w_layer_last;

    assign w_in_fire    = bus.in_valid & r_in_ready;
    assign w_out_fire   = r_out_valid & bus.out_ready;
    assign w_node_last  = (r_node == NODE_LAST);
    assign w_layer_last = (r_layer == LAYER_LAST);

    // Sequencer FSM: state, counters and all state-derived outputs in one place.
    // NOTE: every register here is assigned with <= so all of them update from
    // the same pre-edge values; mixing in = would make the order of the
    // statements change the hardware.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= S_IDLE;
            r_layer        <= '0;
            r_node         <= '0;
            r_settle       <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_in_ready     <= 1'b0;
            r_input_select <= 1'b0;
            r_clr          <= 1'b0;
            r_out_valid    <= 1'b0;
            r_out_last     <= 1'b0;
            r_out_data     <= '0;
        end else begin
            // Single-cycle strobes default low and are raised on transitions.
            r_done <= 1'b0;
            r_clr  <= 1'b0;

            case (r_state)
                // Commands are only honoured here; load has priority over run.
                S_IDLE: begin
                    if (bus.cmd_load) begin
                        r_state    <= S_LOAD;
                        r_busy     <= 1'b1;
                        r_in_ready <= 1'b1;
                        r_layer    <= '0;
                        r_node     <= '0;
                    end else if (bus.cmd_run) begin
                        r_state <= S_CLR;
                        r_busy  <= 1'b1;
                        r_clr   <= 1'b1;
                        r_layer <= '0;
                        r_node  <= '0;
                    end
                end

                // One weight per accepted word, walking node-major through layers.
                S_LOAD: begin
                    if (w_in_fire) begin
                        if (w_node_last) begin
                            r_node <= '0;
                            if (w_layer_last) begin
                                r_layer    <= '0;
                                r_state    <= S_IDLE;
                                r_busy     <= 1'b0;
                                r_in_ready <= 1'b0;
                                r_done     <= 1'b1;
                            end else begin
                                r_layer <= r_layer + 1'b1;
                            end
                        end else begin
                            r_node <= r_node + 1'b1;
                        end
                    end
                end

                // Layer accumulators were cleared this cycle; pick the input source.
                S_CLR: begin
                    r_node <= '0;
                    if (r_layer == '0) begin
                        r_state        <= S_RUN_IN;
                        r_in_ready     <= 1'b1;
                        r_input_select <= 1'b1;
                    end else begin
                        r_state <= S_RUN_FB;
                    end
                end

                // Layer 0 consumes the host input vector; node holds while stalled.
                S_RUN_IN: begin
                    if (w_in_fire) begin
                        if (w_node_last) begin
                            r_node         <= '0;
                            r_state        <= S_SETTLE;
                            r_in_ready     <= 1'b0;
                            r_input_select <= 1'b0;
                        end else begin
                            r_node <= r_node + 1'b1;
                        end
                    end
                end

                // Deeper layers take the previous layer's results, one node per cycle.
                S_RUN_FB: begin
                    if (w_node_last) begin
                        r_node  <= '0;
                        r_state <= S_SETTLE;
                    end else begin
                        r_node <= r_node + 1'b1;
                    end
                end

                // Give the datapath PIPE_LAT cycles to finish the layer.
                S_SETTLE: begin
                    if (r_settle == SETTLE_LAST) begin
                        r_settle <= '0;
                        if (w_layer_last) begin
                            r_state <= S_OUT_FETCH;
                            r_node  <= '0;
                        end else begin
                            r_layer <= r_layer + 1'b1;
                            r_state <= S_CLR;
                            r_clr   <= 1'b1;
                        end
                    end else begin
                        r_settle <= r_settle + 1'b1;
                    end
                end

                // nn_node has addressed the result memory for a full cycle, so
                // nn_y is stable here; capture it and offer it to the host.
                S_OUT_FETCH: begin
                    r_state     <= S_OUT_PRESENT;
                    r_out_data  <= bus.nn_y;
                    r_out_valid <= 1'b1;
                    r_out_last  <= w_node_last;
                end

                // Word is held until the host takes it.
                S_OUT_PRESENT: begin
                    if (w_out_fire) begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                        if (r_out_last) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_node  <= '0;
                            r_layer <= '0;
                        end else begin
                            r_node  <= r_node + 1'b1;
                            r_state <= S_OUT_FETCH;
                        end
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Host-facing status and stream outputs.
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_last  = r_out_last;

    // Datapath controls that follow the FSM registers.
    assign bus.nn_input_select = r_input_select;
    assign bus.nn_clr          = r_clr;
    assign bus.nn_layer        = r_layer;
    assign bus.nn_node         = r_node;

    // NOTE: the write strobe and serial data must coincide with the host
    // handshake cycle itself, so they are decoded from the live handshake
    // rather than registered; in_ready is registered, keeping the path short.
    assign bus.nn_write_enable = (r_state == S_LOAD) & w_in_fire;
    assign bus.nn_data_in      = w_in_fire ? bus.in_data : '0;

endmodule
